// File: rtl/multi_channel_producer_if.sv
// rtl/multi_channel_producer_if.sv - producer-to-pipeline channel bundle
interface multi_channel_producer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        stall;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_flush;

  // producer side
  modport master (input stall, output ch_data, output ch_valid, output ch_flush);
  // pipeline side
  modport slave (output stall, input ch_data, input ch_valid, input ch_flush);
endinterface

// File: rtl/multi_channel_producer.sv
// rtl/multi_channel_producer.sv - per-channel data producer with stall and periodic flush
module multi_channel_producer #(
  parameter int          NUM_CH         = 2,
  parameter int          DATA_W         = 32,
  parameter int          STRIDE         = 2,
  parameter int          FLUSH_INTERVAL = 32,
  parameter int          GEN_MODE       = 0,
  parameter logic [31:0] LFSR_POLY      = 32'h80200003
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       busy,
  multi_channel_producer_if.master   pipe
);

  localparam int CNT_W = (FLUSH_INTERVAL > 0) ? $clog2(FLUSH_INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(FLUSH_INTERVAL);
  localparam logic [DATA_W-1:0] POLY_W    = DATA_W'(LFSR_POLY);
  localparam logic [DATA_W-1:0] STRIDE_W  = DATA_W'(STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  logic [NUM_CH-1:0] active;

  // next generator value: counting step or one Galois LFSR shift
  function automatic logic [DATA_W-1:0] next_gen(input logic [DATA_W-1:0] g);
    if (GEN_MODE == 1)
      return g[0] ? ((g >> 1) ^ POLY_W) : (g >> 1);
    else
      return g + STRIDE_W;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // LFSR seeds start at c+1 so the register never locks up at zero
    localparam logic [DATA_W-1:0] SEED = (GEN_MODE == 1) ? DATA_W'(c + 1) : DATA_W'(c);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] gen_q, gen_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;

    // next-state and output decode; flush outranks stall, enable outranks both
    always_comb begin
      state_d = state_q;
      gen_d   = gen_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      flush_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if ((FLUSH_INTERVAL != 0) && (cnt_q == CNT_LIMIT)) begin
            state_d = FLUSH;
            flush_d = 1'b1;
            cnt_d   = '0;
          end else if (!pipe.stall[c]) begin
            valid_d = 1'b1;
            data_d  = gen_q;
            gen_d   = next_gen(gen_q);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        FLUSH: begin
          state_d = enable ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        gen_q   <= SEED;
        data_q  <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        flush_q <= 1'b0;
      end else begin
        state_q <= state_d;
        gen_q   <= gen_d;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
        flush_q <= flush_d;
      end
    end

    assign pipe.ch_data[c*DATA_W +: DATA_W] = data_q;
    assign pipe.ch_valid[c]                 = valid_q;
    assign pipe.ch_flush[c]                 = flush_q;
    assign active[c]                        = (state_q != IDLE);
  end

  assign busy = |active;

endmodule

// File: tb/tb_multi_channel_producer.sv
// tb/tb_multi_channel_producer.sv - randomized and directed bench for multi_channel_producer
module tb_multi_channel_producer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] stall = 2'b00;
  logic       busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_channel_producer_if #(.NUM_CH(2), .DATA_W(32)) if_a ();
  multi_channel_producer_if #(.NUM_CH(2), .DATA_W(4))  if_b ();
  multi_channel_producer_if #(.NUM_CH(2), .DATA_W(4))  if_c ();

  assign if_a.stall = stall;
  assign if_b.stall = stall;
  assign if_c.stall = stall;

  // counting, flush every 4 items
  multi_channel_producer #(.NUM_CH(2), .DATA_W(32), .STRIDE(2), .FLUSH_INTERVAL(4), .GEN_MODE(0),
                           .LFSR_POLY(32'h80200003)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy_a), .pipe(if_a));
  // 4-bit counter wrap, no flush
  multi_channel_producer #(.NUM_CH(2), .DATA_W(4), .STRIDE(2), .FLUSH_INTERVAL(0), .GEN_MODE(0),
                           .LFSR_POLY(32'h80200003)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy_b), .pipe(if_b));
  // 4-bit LFSR, no flush
  multi_channel_producer #(.NUM_CH(2), .DATA_W(4), .STRIDE(2), .FLUSH_INTERVAL(0), .GEN_MODE(1),
                           .LFSR_POLY(32'h0000000C)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy_c), .pipe(if_c));

  // reference model configuration and state per (dut, channel)
  int          cfg_dw[3]   = '{32, 4, 4};
  int          cfg_fi[3]   = '{4, 0, 0};
  int          cfg_mode[3] = '{0, 0, 1};
  logic [31:0] cfg_poly[3] = '{32'h80200003, 32'h0, 32'hC};

  logic [31:0] m_gen[3][2];
  logic [31:0] m_data[3][2];
  int          m_items[3][2];
  logic        m_flush[3][2];
  logic        en_prev = 1'b0;

  logic        rec = 1'b0;
  logic [31:0] q_b1[$];
  logic [31:0] q_c0[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(int d);
    return (cfg_dw[d] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[d]) - 32'd1);
  endfunction

  function automatic logic [31:0] m_next(int d, logic [31:0] g);
    if (cfg_mode[d] == 1)
      return (g % 2 == 1) ? (((g / 2) ^ cfg_poly[d]) & mask_of(d)) : (g / 2);
    return (g + 32'd2) & mask_of(d);
  endfunction

  function automatic logic [31:0] m_seed(int d, int c);
    return (cfg_mode[d] == 1) ? 32'(c + 1) : 32'(c);
  endfunction

  function automatic logic [31:0] obs_data(int d, int c);
    case (d)
      0:       return if_a.ch_data[c*32 +: 32];
      1:       return {28'b0, if_b.ch_data[c*4 +: 4]};
      default: return {28'b0, if_c.ch_data[c*4 +: 4]};
    endcase
  endfunction

  function automatic logic obs_valid(int d, int c);
    case (d)
      0:       return if_a.ch_valid[c];
      1:       return if_b.ch_valid[c];
      default: return if_c.ch_valid[c];
    endcase
  endfunction

  function automatic logic obs_flush(int d, int c);
    case (d)
      0:       return if_a.ch_flush[c];
      1:       return if_b.ch_flush[c];
      default: return if_c.ch_flush[c];
    endcase
  endfunction

  function automatic logic obs_busy(int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // One clock: drive inputs, then compare every output with the model.
  // A channel may act on an edge only if enable was high on this edge and
  // the previous one and it did not flush on the previous edge; it flushes
  // once it has emitted the interval's worth of items, otherwise emits
  // unless stalled.
  task automatic cycle(input logic en, input logic [1:0] st, input logic rst);
    logic run, mv, mf;
    enable = en;
    stall  = st;
    reset  = rst;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          mv = 1'b0;
          mf = 1'b0;
          m_data[d][c]  = 32'd0;
          m_items[d][c] = 0;
          m_gen[d][c]   = m_seed(d, c);
        end else begin
          run = en_prev && en && !m_flush[d][c];
          mf  = run && (cfg_fi[d] != 0) && (m_items[d][c] == cfg_fi[d]);
          mv  = run && !mf && !st[c];
          if (mf) m_items[d][c] = 0;
          if (mv) begin
            m_data[d][c] = m_gen[d][c];
            m_gen[d][c]  = m_next(d, m_gen[d][c]);
            m_items[d][c]++;
          end
        end
        m_flush[d][c] = mf;
        check($sformatf("d%0d_c%0d_valid", d, c), 32'(obs_valid(d, c)), 32'(mv));
        check($sformatf("d%0d_c%0d_flush", d, c), 32'(obs_flush(d, c)), 32'(mf));
        check($sformatf("d%0d_c%0d_data", d, c), obs_data(d, c), m_data[d][c]);
        if (rec && obs_valid(d, c)) begin
          if (d == 1 && c == 1) q_b1.push_back(obs_data(d, c));
          if (d == 2 && c == 0) q_c0.push_back(obs_data(d, c));
        end
      end
      check($sformatf("d%0d_busy", d), 32'(obs_busy(d)), rst ? 32'd0 : 32'(en));
    end
    en_prev = rst ? 1'b0 : en;
  endtask

  int ta_v0[9]  = '{0, 1, 1, 1, 1, 0, 0, 1, 1};
  int ta_f[9]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int ta_d0[9]  = '{0, 0, 2, 4, 6, 6, 6, 8, 10};
  int ta_d1[9]  = '{0, 1, 3, 5, 7, 7, 7, 9, 11};
  int wrap_exp[10] = '{1, 3, 5, 7, 9, 11, 13, 15, 1, 3};
  int lfsr_exp[6]  = '{1, 12, 6, 3, 13, 10};
  int ts_v0[8]  = '{0, 1, 1, 0, 0, 0, 1, 1};
  int ts_d0[8]  = '{0, 0, 2, 2, 2, 2, 4, 6};
  int ts_v1[8]  = '{0, 1, 1, 1, 1, 0, 0, 1};

  initial begin
    // reset state
    cycle(1'b0, 2'b00, 1'b1);
    cycle(1'b0, 2'b00, 1'b1);
    check("rst_valid", 32'(if_a.ch_valid), 32'd0);
    check("rst_data", if_a.ch_data[31:0], 32'd0);

    // counting with flush, wrap and LFSR sequences
    rec = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 2'b00, 1'b0);
      if (i < 9) begin
        check($sformatf("cnt_v0_e%0d", i + 1), 32'(if_a.ch_valid[0]), 32'(ta_v0[i]));
        check($sformatf("cnt_f0_e%0d", i + 1), 32'(if_a.ch_flush[0]), 32'(ta_f[i]));
        check($sformatf("cnt_f1_e%0d", i + 1), 32'(if_a.ch_flush[1]), 32'(ta_f[i]));
        check($sformatf("cnt_d0_e%0d", i + 1), if_a.ch_data[31:0], 32'(ta_d0[i]));
        check($sformatf("cnt_d1_e%0d", i + 1), if_a.ch_data[63:32], 32'(ta_d1[i]));
      end
    end
    rec = 1'b0;
    for (int i = 0; i < 10; i++)
      check($sformatf("wrap_%0d", i), (i < q_b1.size()) ? q_b1[i] : 32'hDEAD, 32'(wrap_exp[i]));
    for (int i = 0; i < 6; i++)
      check($sformatf("lfsr_%0d", i), (i < q_c0.size()) ? q_c0[i] : 32'hDEAD, 32'(lfsr_exp[i]));

    // stall on channel 0 for three edges after item 2
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, (i >= 3 && i <= 5) ? 2'b01 : 2'b00, 1'b0);
      check($sformatf("stall_v0_e%0d", i + 1), 32'(if_a.ch_valid[0]), 32'(ts_v0[i]));
      check($sformatf("stall_d0_e%0d", i + 1), if_a.ch_data[31:0], 32'(ts_d0[i]));
      check($sformatf("stall_v1_e%0d", i + 1), 32'(if_a.ch_valid[1]), 32'(ts_v1[i]));
    end

    // enable drop after item 4, resume, then reset during FLUSH
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b00, 1'b0);
      check("drop_busy", 32'(busy_a), 32'd0);
      check("drop_valid", 32'(if_a.ch_valid), 32'd0);
    end
    cycle(1'b1, 2'b00, 1'b0);
    check("resume_v0_first", 32'(if_a.ch_valid[0]), 32'd0);
    cycle(1'b1, 2'b00, 1'b0);
    check("resume_v0", 32'(if_a.ch_valid[0]), 32'd1);
    check("resume_d0", if_a.ch_data[31:0], 32'd6);
    cycle(1'b1, 2'b00, 1'b0);
    check("resume_flush0", 32'(if_a.ch_flush[0]), 32'd1);
    cycle(1'b1, 2'b00, 1'b1);
    check("midrst_flush", 32'(if_a.ch_flush), 32'd0);
    check("midrst_valid", 32'(if_a.ch_valid), 32'd0);
    check("midrst_data", if_a.ch_data[31:0] | if_a.ch_data[63:32], 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    cycle(1'b1, 2'b00, 1'b0);
    check("restart_v_lat", 32'(if_a.ch_valid), 32'd0);
    cycle(1'b1, 2'b00, 1'b0);
    check("restart_v", 32'(if_a.ch_valid), 32'd3);
    check("restart_d0", if_a.ch_data[31:0], 32'd0);
    check("restart_d1", if_a.ch_data[63:32], 32'd1);

    // randomized enable / stall / reset traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 7) != 0),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_channel_producer.md
# multi_channel_producer

Parametrised stimulus producer for the global-stall pipeline testbench; successor to the two-channel producer FSM. Drives `NUM_CH` independent pipeline input channels, each with a per-channel data generator, a registered valid, stall back-pressure and a periodic one-cycle flush pulse. Sits at the head of the pipelines and feeds `ch_data`/`ch_valid`/`ch_flush` directly into the pipeline inputs.

## Interface
- `NUM_CH`, 2, number of independent channels (≥1)
- `DATA_W`, 32, width of each channel's data word
- `STRIDE`, 2, increment added per emitted item in counting mode; it is a generic step, not tied to `NUM_CH`
- `FLUSH_INTERVAL`, 32, items emitted per channel between flush pulses; 0 disables flush
- `GEN_MODE`, 0, data generator mode: 0 = counter, 1 = Galois LFSR
- `LFSR_POLY`, 32'h80200003, LFSR feedback mask (low `DATA_W` bits used), used only when `GEN_MODE`=1
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  global run enable, shared by all channels
- `stall`  in  NUM_CH  per-channel stall from pipeline; bit c applies to channel c
- `ch_data`  out  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]; registered
- `ch_valid`  out  NUM_CH  per-channel data valid; registered
- `ch_flush`  out  NUM_CH  per-channel one-cycle flush pulse; registered
- `busy`  out  1  OR over all channels of (state != IDLE); combinational from state

## Operation
- Each channel c has state ∈ {IDLE, RUN, FLUSH}, generator register `gen[c]`, item counter `cnt[c]`. The width of `cnt[c]` is clog2(`FLUSH_INTERVAL`+1), with a minimum of 1 bit.
- Reset seed: `gen[c]` = c in counter mode. In LFSR mode it is c+1, so the seed is never 0.
- Transitions are evaluated per channel at each edge, with priority top-down within a state:
  - IDLE: `enable`=1 → RUN. Otherwise stay. `ch_valid[c]`<=0, `ch_flush[c]`<=0.
  - RUN, `enable`=0 → IDLE. `ch_valid[c]`<=0. `gen` and `cnt` are held.
  - RUN, `FLUSH_INTERVAL`≠0 and `cnt[c]`==`FLUSH_INTERVAL` → FLUSH. `ch_flush[c]`<=1, `ch_valid[c]`<=0, `cnt[c]`<=0. This fires regardless of `stall[c]`.
  - RUN, `stall[c]`=1 → stay. `ch_valid[c]`<=0. `ch_data`, `gen` and `cnt` are held.
  - RUN, otherwise (emit): `ch_valid[c]`<=1, `ch_data[c]`<=`gen[c]`, `gen[c]`<=next(`gen[c]`), `cnt[c]`<=`cnt[c]`+1.
  - FLUSH: `ch_flush[c]`<=0, `ch_valid[c]`<=0. Go to RUN if `enable`=1, else IDLE.
- `ch_flush[c]` is deasserted on every edge that does not take the RUN→FLUSH branch.
- next() in counter mode = (`gen`+`STRIDE`) mod 2^`DATA_W`; wrap-around is silent.
- next() in LFSR mode = lsb ? ((`gen`>>1) ^ `LFSR_POLY`) : (`gen`>>1).
- `ch_data[c]` changes only on emit edges. Between emits it holds the last emitted value, so it is stable while valid is low.
- Channels are fully independent. A stall or flush on one channel never affects another.
- `enable` deasserted mid-stream preserves `gen`/`cnt`. Re-enabling resumes the same sequence and the same flush phase.

## Timing
- Reset values: `ch_valid`=0, `ch_flush`=0, `ch_data`=0, state=IDLE, `cnt`=0, `gen` = seed. `busy`=0.
- Reset has priority over all other inputs, including in mid-FLUSH and mid-stream.
- Start latency: `enable` is sampled high at edge k, giving RUN. The first valid is visible after edge k+1, provided stall is low.
- Stall latency: `stall[c]` sampled high at edge k means `ch_valid[c]`=0 from edge k onward, for one registered cycle per stalled edge.
- Flush cadence, with stall never asserted: `FLUSH_INTERVAL` consecutive valid cycles, then one cycle with flush=1 and valid=0, then one idle cycle (the FLUSH state), then the stream resumes. The valid gap is 2 cycles.
- Flush and valid are never high together on the same channel.

## Test plan
- **Counting with flush.** Set `NUM_CH`=2, `STRIDE`=2, `FLUSH_INTERVAL`=4, `GEN_MODE`=0. Release reset with `enable`=1 and no stall.
  - Ch0 must emit 0,2,4,6, then flush, then 8,10,…
  - Ch1 must emit 1,3,5,7, then flush.
  - The flush pulses are 1 cycle wide and valid is 0 during each pulse.
- **Stall on one channel.** Same setup, with `stall[0]` held high for 3 edges after the item 2.
  - Ch0 valid must be low for 3 cycles, `ch_data[0]` must hold 2, and the next value must be 4.
  - Ch1's sequence must be unaffected.
- **Counter wrap.** Set `DATA_W`=4, `STRIDE`=2, `FLUSH_INTERVAL`=0. Ch1 must emit 1,3,…,13,15,1,3, and `ch_flush` must never assert.
- **LFSR mode.** Set `GEN_MODE`=1, `DATA_W`=4, `LFSR_POLY`=4'hC, `FLUSH_INTERVAL`=0. Ch0 must emit 1,12,6,3,13,10.
- **Enable drop and resume.** Deassert `enable` after ch0 emits 4, for 5 cycles.
  - Valid must be low and `busy` must fall 1 edge later.
  - On re-enable, ch0 must emit 6 first, and the flush must still occur after the 4th item since the last flush.
- **Reset mid-operation.** Assert `reset` for 1 edge while ch0 is in FLUSH.
  - After that edge all outputs must be 0, `busy`=0, and the flush pulse must be cut.
  - After reset, the sequence must restart at 0/1 with the start latency given in Timing.
